// File: rtl/pipeline_load_control.sv
// Load/flush sequencing for the LC-3b pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
// Optional performance counters are enabled by defining PIPE_PERF_COUNTERS_EN.
//
// state   | meaning
// INIT    | first cycle after reset: flush front registers, retire zero MEM/WB
// RUN     | pipeline advancing normally
// STALL_D | last cycle froze everything waiting on the data cache
// STALL_F | last cycle stalled the front end (fetch miss, load-use, or held branch)
module pipeline_load_control #(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_front,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {INIT, RUN, STALL_D, STALL_F} state_t;

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;
  logic              stall_now;
  logic              flush_now;
  logic              dbusy;
  logic              fbusy;

  assign dbusy = dcache_req & ~dcache_resp;
  assign fbusy = ~icache_resp | load_use_hazard;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    timeout_d    = timeout_q;
    stall_now    = 1'b0;
    flush_now    = 1'b0;
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_front  = 1'b0;

    if (!reset) begin
      case (state_q)
        INIT: begin
          // Front registers load zeros; the PC keeps its reset vector.
          load_if_id  = 1'b1;
          load_id_ex  = 1'b1;
          load_ex_mem = 1'b1;
          load_mem_wb = 1'b1;
          flush_front = 1'b1;
          wait_d      = '0;
          state_d     = RUN;
        end
        default: begin
          if (dbusy) begin
            stall_now = 1'b1;
            state_d   = STALL_D;
          end else if (branch_taken && !icache_resp) begin
            // Branch stays in EX/MEM and is retried once fetch is ready.
            stall_now = 1'b1;
            state_d   = STALL_F;
          end else if (branch_taken) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_front = 1'b1;
            flush_now   = 1'b1;
            state_d     = RUN;
          end else if (fbusy) begin
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            bubble_id_ex = 1'b1;
            stall_now    = 1'b1;
            state_d      = STALL_F;
          end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            state_d     = RUN;
          end

          if (stall_now) begin
            wait_d    = (wait_q == WAIT_MAX) ? WAIT_MAX : wait_q + 1'b1;
            timeout_d = timeout_q | (wait_d == WAIT_MAX);
          end else begin
            wait_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q & ~reset;

`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_now && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_now && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = reset ? '0 : stall_cnt_q;
  assign flush_count  = reset ? '0 : flush_cnt_q;
`else
  logic unused_perf;
  assign unused_perf  = stall_now ^ flush_now;
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
